mux_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one 4:1 bit-select datapath between four requesters. Each requester owns one mux input bit, din[k]. The arbiter grants one requester at a time and drives the mux select from the grant. It also registers the selected bit onto a single shared output with a valid flag. The block sits in front of the four_to_one_mux datapath and is its only sequencing controller.

---
 rtl/mux_arb_pkg.sv | 43 ++++
 rtl/four_to_one_mux.sv | 10 +
 rtl/mux_rr_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mux_rr_arbiter.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Shared definitions for the round-robin bit-select arbiter: sizes, state
// encoding and the rotating priority search.
package mux_arb_pkg;

   localparam int N_REQ = 4;
   localparam int SEL_W = 2;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   typedef struct packed {
      logic             found;
      logic [SEL_W-1:0] idx;
   } pick_t;

   // First set request bit searching ptr, ptr+1, ... with natural 2-bit wrap.
   function automatic pick_t rr_pick(input logic [N_REQ-1:0] req,
                                     input logic [SEL_W-1:0] ptr);
      pick_t            res;
      logic [SEL_W-1:0] cand;
      res.found = 1'b0;
      res.idx   = ptr;
      for (int i = 0; i < N_REQ; i++) begin
         cand = ptr + SEL_W'(i);
         if (!res.found && req[cand]) begin
            res.found = 1'b1;
            res.idx   = cand;
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

   function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
      logic [N_REQ-1:0] one;
      one = {{(N_REQ-1){1'b0}}, 1'b1};
      return one << idx;
   endfunction

endpackage

// File: rtl/four_to_one_mux.sv
// 4:1 single-bit select datapath shared by the four requesters.
module four_to_one_mux (
   input  logic [3:0] i,
   input  logic [1:0] s,
   output logic       y
);

   assign y = i[s];

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin controller for four_to_one_mux with registered grant, select and data.
// Optional hold limit (forced rotation after MAX_HOLD cycles) enabled by MUX_ARB_HOLD_LIMIT_EN.
module mux_rr_arbiter
   import mux_arb_pkg::*;
#(
   parameter int MAX_HOLD = 8,
   parameter int HOLD_W   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ-1:0] din,
   output logic [N_REQ-1:0] gnt,
   output logic [SEL_W-1:0] sel,
   output logic             y,
   output logic             y_valid,
   output logic             busy
);

   if ((MAX_HOLD < 1) || (MAX_HOLD > (1 << HOLD_W))) begin : g_bad_hold
      $error("mux_rr_arbiter: MAX_HOLD out of range for HOLD_W");
   end

   arb_state_t       r_state;
   arb_state_t       w_state_nxt;
   logic [N_REQ-1:0] r_gnt;
   logic [N_REQ-1:0] w_gnt_nxt;
   logic [SEL_W-1:0] r_sel;
   logic [SEL_W-1:0] w_sel_nxt;
   logic [SEL_W-1:0] r_ptr;
   logic [SEL_W-1:0] w_ptr_nxt;
   logic             r_busy;
   logic             w_busy_nxt;
   logic             r_y;
   logic             r_y_valid;
   logic             w_mux_y;
   logic             w_release;
   logic [N_REQ-1:0] w_others;
   pick_t            w_pick_idle;
   pick_t            w_pick_next;

   four_to_one_mux u_mux (
      .i (din),
      .s (r_sel),
      .y (w_mux_y)
   );

   // The owner's own bit is masked so a pre-empted owner is served last.
   assign w_others    = req & ~r_gnt;
   assign w_pick_idle = rr_pick(req, r_ptr);
   assign w_pick_next = rr_pick(w_others, r_sel + 2'd1);

`ifdef MUX_ARB_HOLD_LIMIT_EN
   logic [HOLD_W-1:0] r_hold_cnt;
   logic [HOLD_W-1:0] w_hold_nxt;
   logic              w_hold_hit;

   assign w_hold_hit = (r_hold_cnt == HOLD_W'(MAX_HOLD - 1));
   assign w_release  = !req[r_sel] || (w_hold_hit && (|w_others));

   // Hold counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hold_cnt <= {HOLD_W{1'b0}};
      end else begin
         r_hold_cnt <= w_hold_nxt;
      end
   end

   // Hold counter next value: clear on new grant, saturate while held.
   always_comb begin
      w_hold_nxt = r_hold_cnt;
      case (r_state)
         IDLE: begin
            w_hold_nxt = {HOLD_W{1'b0}};
         end
         GRANT: begin
            if (w_release) begin
               w_hold_nxt = {HOLD_W{1'b0}};
            end else if (!w_hold_hit) begin
               w_hold_nxt = r_hold_cnt + {{(HOLD_W-1){1'b0}}, 1'b1};
            end else begin
               w_hold_nxt = r_hold_cnt;
            end
         end
         default: begin
            w_hold_nxt = {HOLD_W{1'b0}};
         end
      endcase
   end
`else
   assign w_release = !req[r_sel];
`endif

   // Arbitration FSM next-state and grant decode.
   always_comb begin
      w_state_nxt = r_state;
      w_gnt_nxt   = r_gnt;
      w_sel_nxt   = r_sel;
      w_ptr_nxt   = r_ptr;
      w_busy_nxt  = r_busy;
      case (r_state)
         IDLE: begin
            if (w_pick_idle.found) begin
               w_state_nxt = GRANT;
               w_gnt_nxt   = onehot(w_pick_idle.idx);
               w_sel_nxt   = w_pick_idle.idx;
               w_busy_nxt  = 1'b1;
            end else begin
               w_gnt_nxt  = {N_REQ{1'b0}};
               w_busy_nxt = 1'b0;
            end
         end
         GRANT: begin
            if (w_release) begin
               w_ptr_nxt = r_sel + 2'd1;
               if (w_pick_next.found) begin
                  w_gnt_nxt = onehot(w_pick_next.idx);
                  w_sel_nxt = w_pick_next.idx;
               end else begin
                  w_state_nxt = IDLE;
                  w_gnt_nxt   = {N_REQ{1'b0}};
                  w_busy_nxt  = 1'b0;
               end
            end else begin
               w_gnt_nxt = r_gnt;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_gnt_nxt   = {N_REQ{1'b0}};
            w_busy_nxt  = 1'b0;
         end
      endcase
   end

   // Control state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_gnt   <= {N_REQ{1'b0}};
         r_sel   <= {SEL_W{1'b0}};
         r_ptr   <= {SEL_W{1'b0}};
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_gnt   <= w_gnt_nxt;
         r_sel   <= w_sel_nxt;
         r_ptr   <= w_ptr_nxt;
         r_busy  <= w_busy_nxt;
      end
   end

   // Data capture: y keeps its last value once the path goes idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_y       <= 1'b0;
         r_y_valid <= 1'b0;
      end else if (r_state == GRANT) begin
         r_y       <= w_mux_y;
         r_y_valid <= 1'b1;
      end else begin
         r_y_valid <= 1'b0;
      end
   end

   assign gnt     = r_gnt;
   assign sel     = r_sel;
   assign y       = r_y;
   assign y_valid = r_y_valid;
   assign busy    = r_busy;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter: directed steps queue expected outputs,
// a negedge monitor pops and compares them.
module tb_mux_rr_arbiter;

   logic       clk;
   logic       rst;
   logic [3:0] req;
   logic [3:0] din;
   logic [3:0] gnt;
   logic [1:0] sel;
   logic       y;
   logic       y_valid;
   logic       busy;

   typedef struct {
      int         cyc;
      string      tag;
      logic [8:0] exp;
   } exp_t;

   exp_t q[$];
   int   cyc    = 0;
   int   n_cmp  = 0;
   int   n_bad  = 0;

   mux_rr_arbiter #(.MAX_HOLD(4), .HOLD_W(4)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .din     (din),
      .gnt     (gnt),
      .sel     (sel),
      .y       (y),
      .y_valid (y_valid),
      .busy    (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [8:0] act, input logic [8:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: gnt/sel/y/yv/busy got %b_%b_%b_%b_%b required %b_%b_%b_%b_%b",
                  tag, act[8:5], act[4:3], act[2], act[1], act[0],
                  exp[8:5], exp[4:3], exp[2], exp[1], exp[0]);
      end
   endtask

   // Monitor: compare the output set produced by each edge against the queue.
   always @(negedge clk) begin
      if (q.size() > 0) begin
         if (q[0].cyc < cyc) begin
            exp_t e;
            e = q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL %s: expectation for cycle %0d not compared (now %0d)", e.tag, e.cyc, cyc);
         end else if (q[0].cyc == cyc) begin
            exp_t e;
            e = q.pop_front();
            check(e.tag, {gnt, sel, y, y_valid, busy}, e.exp);
         end
      end
   end

   // Apply inputs now; the expected outputs belong to the next rising edge.
   task automatic step(input string tag, input logic [3:0] r, input logic [3:0] d,
                       input logic [3:0] eg, input logic [1:0] es, input logic ey,
                       input logic eyv, input logic eb);
      exp_t e;
      req   = r;
      din   = d;
      e.cyc = cyc + 1;
      e.tag = tag;
      e.exp = {eg, es, ey, eyv, eb};
      q.push_back(e);
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      check(tag, {gnt, sel, y, y_valid, busy}, 9'b0);
      @(posedge clk);
      #2;
      rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      req = 4'b0000;
      din = 4'b0000;
      #1;
      check("reset_state", {gnt, sel, y, y_valid, busy}, 9'b0);
      @(posedge clk);
      #2;
      rst = 1'b0;

      // Single requester
      step("single_grant", 4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b0, 1'b0, 1'b1);
      step("single_data",  4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1, 1'b1);
      step("single_drop",  4'b0000, 4'b0100, 4'b0000, 2'd2, 1'b1, 1'b1, 1'b0);
      step("single_idle",  4'b0000, 4'b0100, 4'b0000, 2'd2, 1'b1, 1'b0, 1'b0);

      // Data path, din=1010 then 0101, requesters 1 and 3 (ptr=3 first)
      step("dp1_g3",   4'b1010, 4'b1010, 4'b1000, 2'd3, 1'b1, 1'b0, 1'b1);
      step("dp1_g1",   4'b0010, 4'b1010, 4'b0010, 2'd1, 1'b1, 1'b1, 1'b1);
      step("dp1_drop", 4'b0000, 4'b1010, 4'b0000, 2'd1, 1'b1, 1'b1, 1'b0);
      step("dp1_idle", 4'b0000, 4'b1010, 4'b0000, 2'd1, 1'b1, 1'b0, 1'b0);
      step("dp0_g3",   4'b1010, 4'b0101, 4'b1000, 2'd3, 1'b1, 1'b0, 1'b1);
      step("dp0_g1",   4'b0010, 4'b0101, 4'b0010, 2'd1, 1'b0, 1'b1, 1'b1);
      step("dp0_drop", 4'b0000, 4'b0101, 4'b0000, 2'd1, 1'b0, 1'b1, 1'b0);
      step("dp0_idle", 4'b0000, 4'b0101, 4'b0000, 2'd1, 1'b0, 1'b0, 1'b0);

      // Pointer wrap: owner 3 releases with req=0011 -> 0
      step("wrap_g3",   4'b1000, 4'b0000, 4'b1000, 2'd3, 1'b0, 1'b0, 1'b1);
      step("wrap_g0",   4'b0011, 4'b1001, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b1);
      step("wrap_g1",   4'b0010, 4'b1001, 4'b0010, 2'd1, 1'b1, 1'b1, 1'b1);
      step("wrap_drop", 4'b0000, 4'b1001, 4'b0000, 2'd1, 1'b0, 1'b1, 1'b0);
      step("wrap_idle", 4'b0000, 4'b1001, 4'b0000, 2'd1, 1'b0, 1'b0, 1'b0);

      // Mid-grant asynchronous reset, then grant to 1 after release
      step("pre_rst_g1",   4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b0, 1'b0, 1'b1);
      step("pre_rst_hold", 4'b0010, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b1, 1'b1);
      do_reset("reset_mid_grant");
      step("post_rst_g1",  4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b0, 1'b0, 1'b1);
      step("post_rst_drop", 4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b1, 1'b0);
      do_reset("reset_idle");

      // Rotation 0,1,2,3,0 with no bubble; din[0..3] = 0,1,1,0
      step("rot_g0",   4'b1111, 4'b0110, 4'b0001, 2'd0, 1'b0, 1'b0, 1'b1);
      step("rot_g1",   4'b1110, 4'b0110, 4'b0010, 2'd1, 1'b0, 1'b1, 1'b1);
      step("rot_g2",   4'b1101, 4'b0110, 4'b0100, 2'd2, 1'b1, 1'b1, 1'b1);
      step("rot_g3",   4'b1011, 4'b0110, 4'b1000, 2'd3, 1'b1, 1'b1, 1'b1);
      step("rot_g0b",  4'b0111, 4'b0110, 4'b0001, 2'd0, 1'b0, 1'b1, 1'b1);
      step("rot_drop", 4'b0000, 4'b0110, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0);
      step("rot_idle", 4'b0000, 4'b0110, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);

      // Hold: req[0] held, req[2] joins; din[0]=1, din[2]=0
      step("hold_g0", 4'b0001, 4'b0001, 4'b0001, 2'd0, 1'b0, 1'b0, 1'b1);
      step("hold_c1", 4'b0101, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b1);
      step("hold_c2", 4'b0101, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b1);
      step("hold_c3", 4'b0101, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b1);
`ifdef MUX_ARB_HOLD_LIMIT_EN
      step("hold_preempt", 4'b0101, 4'b0001, 4'b0100, 2'd2, 1'b1, 1'b1, 1'b1);
      step("hold_g2",      4'b0101, 4'b0001, 4'b0100, 2'd2, 1'b0, 1'b1, 1'b1);
      step("hold_back0",   4'b0001, 4'b0001, 4'b0001, 2'd0, 1'b0, 1'b1, 1'b1);
`else
      for (int i = 0; i < 10; i++) begin
         step("hold_keep", 4'b0101, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b1);
      end
      step("hold_only0", 4'b0001, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b1);
`endif
      step("hold_drop", 4'b0000, 4'b0001, 4'b0000, 2'd0, 1'b1, 1'b1, 1'b0);
      step("hold_idle", 4'b0000, 4'b0001, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0);

      repeat (3) @(negedge clk);
      if (q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: %0d expectations left, required 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
